// File: rtl/multi_timer_switch.sv
// Multi-channel stairwell-style light timer: per-channel ON/WARN/HOLD FSM with
// retrigger, long-press permanent-on, master off and a registered active count.

module mts_lane #(
  parameter int ON_TIME    = 20,
  parameter int WARN_TIME  = 5,
  parameter int LONG_PRESS = 3
) (
  input  logic clock_1Hz,
  input  logic reset,
  input  logic i_btn,
  input  logic i_all_off,
  output logic o_light,
  output logic o_active,
  output logic o_act_nxt
);
  localparam int TW = $clog2(ON_TIME);
  localparam int PW = $clog2(LONG_PRESS + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(ON_TIME - 1);
  localparam logic [TW-1:0] T_WARN = TW'(WARN_TIME);
  localparam logic [PW-1:0] P_MAX  = PW'(LONG_PRESS);
  localparam logic [PW-1:0] P_LAST = PW'(LONG_PRESS - 1);

  typedef enum logic [1:0] {S_OFF, S_ON, S_WARN, S_HOLD} state_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic [PW-1:0]   r_press, w_press_nxt;
  logic            r_btn_q, r_light, r_active;
  logic            w_rise, w_long, w_light_nxt;

  assign w_rise = i_btn & ~r_btn_q;
  assign w_long = i_btn & (r_press == P_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    if (i_all_off) begin
      w_state_nxt = S_OFF;
    end else begin
      case (r_state)
        S_OFF: begin
          if (w_rise) begin
            w_state_nxt = S_ON;
            w_timer_nxt = T_LOAD;
          end
        end
        S_ON, S_WARN: begin
          // retrigger beats long press, long press beats expiry
          if (w_rise) begin
            w_state_nxt = S_ON;
            w_timer_nxt = T_LOAD;
          end else if (w_long) begin
            w_state_nxt = S_HOLD;
          end else if (r_timer == '0) begin
            w_state_nxt = S_OFF;
          end else begin
            w_timer_nxt = r_timer - TW'(1);
            if (r_state == S_ON && WARN_TIME != 0 && r_timer == T_WARN)
              w_state_nxt = S_WARN;
          end
        end
        S_HOLD: begin
          if (w_rise) w_state_nxt = S_OFF;
        end
        default: w_state_nxt = S_OFF;
      endcase
    end
    if (w_state_nxt == S_OFF) w_timer_nxt = '0;
  end

  // Clearing in HOLD keeps a press that starts there from re-arming HOLD.
  always_comb begin
    w_press_nxt = r_press;
    if (i_all_off || !i_btn || r_state == S_HOLD) w_press_nxt = '0;
    else if (r_press != P_MAX)                    w_press_nxt = r_press + PW'(1);
  end

  always_comb begin
    case (w_state_nxt)
      S_ON, S_HOLD: w_light_nxt = 1'b1;
      S_WARN:       w_light_nxt = (r_state == S_WARN) ? ~r_light : 1'b0;
      default:      w_light_nxt = 1'b0;
    endcase
  end

  assign o_act_nxt = (w_state_nxt != S_OFF);

  always_ff @(posedge clock_1Hz or posedge reset) begin
    if (reset) begin
      r_state  <= S_OFF;
      r_timer  <= '0;
      r_press  <= '0;
      r_btn_q  <= 1'b1;
      r_light  <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_press  <= w_press_nxt;
      r_btn_q  <= i_btn;
      r_light  <= w_light_nxt;
      r_active <= o_act_nxt;
    end
  end

  assign o_light  = r_light;
  assign o_active = r_active;
endmodule

module multi_timer_switch #(
  parameter int N          = 4,
  parameter int ON_TIME    = 20,
  parameter int WARN_TIME  = 5,
  parameter int LONG_PRESS = 3
) (
  input  logic                     clock_1Hz,
  input  logic                     reset,
  input  logic [N-1:0]             btn,
  input  logic                     all_off,
  output logic [N-1:0]             light,
  output logic [N-1:0]             active,
  output logic [$clog2(N+1)-1:0]   active_count
);
  localparam int CW = $clog2(N + 1);

  if (N < 1 || N > 32) begin : g_bad_n
    $error("multi_timer_switch: N must be 1..32");
  end
  if (ON_TIME < 2) begin : g_bad_on
    $error("multi_timer_switch: ON_TIME must be >= 2");
  end
  if (WARN_TIME < 0 || WARN_TIME >= ON_TIME) begin : g_bad_warn
    $error("multi_timer_switch: WARN_TIME must be 0..ON_TIME-1");
  end
  if (LONG_PRESS < 2) begin : g_bad_lp
    $error("multi_timer_switch: LONG_PRESS must be >= 2");
  end

  logic [N-1:0]  w_act_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] r_count;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    mts_lane #(
      .ON_TIME   (ON_TIME),
      .WARN_TIME (WARN_TIME),
      .LONG_PRESS(LONG_PRESS)
    ) u_lane (
      .clock_1Hz(clock_1Hz),
      .reset    (reset),
      .i_btn    (btn[gi]),
      .i_all_off(all_off),
      .o_light  (light[gi]),
      .o_active (active[gi]),
      .o_act_nxt(w_act_nxt[gi])
    );
  end

  // Count the next-state vector so the registered count lines up with active.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < N; i++) w_cnt_nxt = w_cnt_nxt + CW'(w_act_nxt[i]);
  end

  always_ff @(posedge clock_1Hz or posedge reset) begin
    if (reset) r_count <= '0;
    else       r_count <= w_cnt_nxt;
  end

  assign active_count = r_count;
endmodule

// File: tb/tb_multi_timer_switch.sv
// Directed bench for multi_timer_switch at default parameters (N=4, 20/5/3).

module tb_multi_timer_switch;
  logic       clk;
  logic       reset;
  logic [3:0] btn;
  logic       all_off;
  logic [3:0] light;
  logic [3:0] active;
  logic [2:0] active_count;
  logic [3:0] btn_prev;
  logic [3:0] hold_ph;
  int         n_chk;
  int         n_pass;

  multi_timer_switch #(.N(4), .ON_TIME(20), .WARN_TIME(5), .LONG_PRESS(3)) dut (
    .clock_1Hz   (clk),
    .reset       (reset),
    .btn         (btn),
    .all_off     (all_off),
    .light       (light),
    .active      (active),
    .active_count(active_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) btn_prev <= '1;
    else       btn_prev <= btn;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_rise
    a_rise: assert property (@(posedge clk) disable iff (reset)
      (btn[gi] && !btn_prev[gi] && !all_off && !hold_ph[gi]) |=> light[gi]);
  end
  a_rst: assert property (@(posedge clk)
    reset |=> (light == 4'h0 && active == 4'h0 && active_count == 3'd0));
  a_cnt: assert property (@(posedge clk) active_count == 3'($countones(active)));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    else             n_pass++;
  endtask

  // light expected r cycles after a single un-retriggered rise
  function automatic logic lexp(input int r);
    if (r <= 15) return 1'b1;
    if (r <= 20) return (r % 2) == 1;
    return 1'b0;
  endfunction

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b1; btn = '0; all_off = 1'b0; hold_ph = '0;
    repeat (2) @(negedge clk);
    chk("rst light", 32'(light), 0);
    chk("rst active", 32'(active), 0);
    chk("rst count", 32'(active_count), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-rst light", 32'(light), 0);
    chk("post-rst active", 32'(active), 0);
    @(negedge clk);

    // single 1-cycle press on ch0
    btn = 4'b0001;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) btn = '0;
      chk($sformatf("single light0 c%0d", k), 32'(light[0]), 32'(lexp(k)));
      chk($sformatf("single active0 c%0d", k), 32'(active[0]), 32'(k <= 20));
      if (k == 1)  chk("single count c1", 32'(active_count), 1);
      if (k == 21) chk("single count c21", 32'(active_count), 0);
    end
    repeat (2) @(negedge clk);

    // retrigger on ch1 ten cycles after the first rise
    btn = 4'b0010;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk($sformatf("retrig active1 c%0d", k), 32'(active[1]), 32'(k <= 30));
      chk($sformatf("retrig light1 c%0d", k), 32'(light[1]),
          32'((k <= 10) ? 1'b1 : lexp(k - 10)));
      if (k == 1 || k == 11) btn = '0;
      if (k == 10) btn = 4'b0010;
    end
    repeat (2) @(negedge clk);

    // long press on ch2 -> HOLD, then exit with a held press
    hold_ph = 4'b0100;
    btn = 4'b0100;
    repeat (3) @(negedge clk);
    btn = '0;
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      if (k % 10 == 0) begin
        chk($sformatf("hold light2 c%0d", k), 32'(light[2]), 1);
        chk($sformatf("hold active2 c%0d", k), 32'(active[2]), 1);
      end
    end
    btn = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 4) btn = '0;
      chk($sformatf("hold exit light2 c%0d", k), 32'(light[2]), 0);
      chk($sformatf("hold exit active2 c%0d", k), 32'(active[2]), 0);
    end
    hold_ph = '0;
    @(negedge clk);

    // simultaneous rises, then all_off colliding with a ch0 rise
    btn = 4'hF;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("conc count", 32'(active_count), 4);
        chk("conc active", 32'(active), 32'hF);
        chk("conc light", 32'(light), 32'hF);
        btn = '0;
      end
      if (k == 8) begin
        all_off = 1'b1;
        btn = 4'b0001;
      end
      if (k == 9) begin
        chk("alloff light", 32'(light), 0);
        chk("alloff active", 32'(active), 0);
        chk("alloff count", 32'(active_count), 0);
        all_off = 1'b0;
        btn = '0;
      end
      if (k == 10) chk("alloff count after", 32'(active_count), 0);
    end

    // reset during WARN on ch3 with btn[3] held through release
    btn = 4'b1000;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 1) btn = '0;
    end
    chk("warn light3 c17", 32'(light[3]), 1);
    chk("warn active3 c17", 32'(active[3]), 1);
    btn = 4'b1000;
    #2 reset = 1'b1;
    #1;
    chk("async rst light3", 32'(light[3]), 0);
    chk("async rst active3", 32'(active[3]), 0);
    chk("async rst count", 32'(active_count), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("held-rel light3 c%0d", k), 32'(light[3]), 0);
      chk($sformatf("held-rel active3 c%0d", k), 32'(active[3]), 0);
    end
    btn = '0;
    @(negedge clk);
    btn = 4'b1000;
    @(negedge clk);
    chk("re-rise light3", 32'(light[3]), 1);
    chk("re-rise count", 32'(active_count), 1);
    btn = '0;
    all_off = 1'b1;
    @(negedge clk);
    all_off = 1'b0;
    chk("final active", 32'(active), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
